// File: rtl/mux_lane_arbiter_if.sv
// mux_lane_arbiter_if: request, lane and response signals of the mux lane
// arbiter. The master modport is the arbiter's view; the slave modport is
// the view of the requesters, the mux lane and the response consumer.
interface mux_lane_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic [1:0]       req0_sel;
   logic [WIDTH-1:0] req0_data;
   logic             req0_ready;
   logic             req1_valid;
   logic [1:0]       req1_sel;
   logic [WIDTH-1:0] req1_data;
   logic             req1_ready;
   logic [1:0]       mux_sel;
   logic [WIDTH-1:0] mux_in;
   logic [WIDTH-1:0] mux_out;
   logic             rsp_valid;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_ready;

   modport master (
      input  req0_valid, req0_sel, req0_data,
      input  req1_valid, req1_sel, req1_data,
      output req0_ready, req1_ready,
      output mux_sel, mux_in,
      input  mux_out,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready
   );

   modport slave (
      output req0_valid, req0_sel, req0_data,
      output req1_valid, req1_sel, req1_data,
      input  req0_ready, req1_ready,
      input  mux_sel, mux_in,
      output mux_out,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready
   );
endinterface

// File: rtl/mux_lane_arbiter.sv
// mux_lane_arbiter: shares one lane of the constant-select mux unit between
// two requesters. One request at a time is latched onto the lane, the lane
// output is captured a cycle later and returned with the requester ID.
// Optional macro MUX_ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous
// requests and the round-robin pointer is removed.
module mux_lane_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   mux_lane_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             win_vld;
   logic             win_id;
   logic             hs;
   logic             gnt0;
   logic             gnt1;
   logic             id_q;
   logic [1:0]       sel_q;
   logic [WIDTH-1:0] in_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_valid_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
   logic             ptr_q;
`endif

   // Winner among the valid requesters
   always_comb begin
      win_vld = bus.req0_valid | bus.req1_valid;
`ifdef MUX_ARB_FIXED_PRIO_EN
      win_id  = ~bus.req0_valid;
`else
      if (bus.req0_valid && bus.req1_valid) begin
         win_id = ptr_q;
      end else begin
         win_id = bus.req1_valid;
      end
`endif
   end

   // Next state and grant decode; grants only exist in IDLE
   always_comb begin
      state_d = state_q;
      hs      = 1'b0;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               gnt0    = ~win_id;
               gnt1    = win_id;
               hs      = 1'b1;
               state_d = DRIVE;
            end
         end
         DRIVE: state_d = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Readies are masked while reset is held so nothing looks accepted
   assign bus.req0_ready = gnt0 & ~rst;
   assign bus.req1_ready = gnt1 & ~rst;

   // State, response-valid and priority pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rsp_valid_q <= 1'b0;
`ifndef MUX_ARB_FIXED_PRIO_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == DRIVE) begin
            rsp_valid_q <= 1'b1;
         end else if (state_q == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
`ifndef MUX_ARB_FIXED_PRIO_EN
         // Hand priority to the requester that did not just complete
         if (state_q == RESP && bus.rsp_ready) begin
            ptr_q <= ~id_q;
         end
`endif
      end
   end

   // Lane select/data and owner ID latched on the handshake, held otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q <= 2'd0;
         in_q  <= '0;
         id_q  <= 1'b0;
      end else if (hs) begin
         sel_q <= win_id ? bus.req1_sel  : bus.req0_sel;
         in_q  <= win_id ? bus.req1_data : bus.req0_data;
         id_q  <= win_id;
      end
   end

   // Lane output captured at the end of the single DRIVE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data_q <= '0;
      end else if (state_q == DRIVE) begin
         rsp_data_q <= bus.mux_out;
      end
   end

   assign bus.mux_sel   = sel_q;
   assign bus.mux_in    = in_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mux_lane_arbiter.sv
// tb_mux_lane_arbiter: directed bench for mux_lane_arbiter with a behavioural
// model of the mux lane (code 0 passes in, codes 1-3 give 0x01/0x02/0x03).
module tb_mux_lane_arbiter;

`ifdef MUX_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mux_lane_arbiter_if #(.WIDTH(8)) bus ();

   mux_lane_arbiter #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mux lane model
   always_comb begin
      bus.mux_out = bus.mux_in;
      case (bus.mux_sel)
         2'd1: bus.mux_out = 8'h01;
         2'd2: bus.mux_out = 8'h02;
         2'd3: bus.mux_out = 8'h03;
         default: bus.mux_out = bus.mux_in;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int hs_cyc [0:2];
   int gnt [0:7];
   int nhs;
   int nrsp;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_sel   = 2'd0;
      bus.req0_data  = 8'h00;
      bus.req1_valid = 1'b0;
      bus.req1_sel   = 2'd0;
      bus.req1_data  = 8'h00;
      bus.rsp_ready  = 1'b0;

      // Reset state, with a request presented during reset
      step();
      check("rst_req0_ready", 32'(bus.req0_ready), 0);
      check("rst_req1_ready", 32'(bus.req1_ready), 0);
      check("rst_mux_sel",    32'(bus.mux_sel),    0);
      check("rst_mux_in",     32'(bus.mux_in),     0);
      check("rst_rsp_valid",  32'(bus.rsp_valid),  0);
      check("rst_rsp_id",     32'(bus.rsp_id),     0);
      check("rst_rsp_data",   32'(bus.rsp_data),   0);
      bus.req0_valid = 1'b0;
      rst = 1'b0;

      // Single pass-through on requester 0, then back-pressure
      bus.req0_valid = 1'b1;
      bus.req0_sel   = 2'd0;
      bus.req0_data  = 8'h5A;
      #1;
      check("pt_req0_ready", 32'(bus.req0_ready), 1);
      check("pt_req1_ready", 32'(bus.req1_ready), 0);
      step();
      bus.req0_valid = 1'b0;
      check("pt_mux_sel",   32'(bus.mux_sel),   0);
      check("pt_mux_in",    32'(bus.mux_in),    'h5A);
      check("pt_rsp_valid_e0", 32'(bus.rsp_valid), 0);
      check("pt_drive_ready", 32'(bus.req0_ready), 0);
      step();
      check("pt_rsp_valid", 32'(bus.rsp_valid), 1);
      check("pt_rsp_id",    32'(bus.rsp_id),    0);
      check("pt_rsp_data",  32'(bus.rsp_data),  'h5A);
      bus.req1_valid = 1'b1;
      bus.req1_sel   = 2'd3;
      #1;
      check("bp_req1_ready_hold", 32'(bus.req1_ready), 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_rsp_valid",  32'(bus.rsp_valid),  1);
         check("bp_rsp_id",     32'(bus.rsp_id),     0);
         check("bp_rsp_data",   32'(bus.rsp_data),   'h5A);
         check("bp_req0_ready", 32'(bus.req0_ready), 0);
         check("bp_req1_ready", 32'(bus.req1_ready), 0);
      end
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      step();
      check("bp_done_rsp_valid", 32'(bus.rsp_valid), 0);

      // Lane constants from requester 1, issued back-to-back
      bus.req1_valid = 1'b1;
      bus.req1_sel   = 2'd1;
      bus.req1_data  = 8'hEE;
      nhs  = 0;
      nrsp = 0;
      #1;
      for (int c = 0; c < 40 && nrsp < 3; c++) begin
         logic hs;
         if (bus.rsp_valid) begin
            check("const_rsp_id",   32'(bus.rsp_id),   1);
            check("const_rsp_data", 32'(bus.rsp_data), nrsp + 1);
            nrsp++;
         end
         hs = bus.req1_valid & bus.req1_ready;
         step();
         if (hs) begin
            if (nhs < 3) hs_cyc[nhs] = c;
            nhs++;
            if (nhs < 3) begin
               bus.req1_sel = 2'(nhs + 1);
            end else begin
               bus.req1_valid = 1'b0;
            end
         end
      end
      check("const_rsp_count", nrsp, 3);
      check("const_hs_count",  nhs,  3);
      check("const_gap_01", hs_cyc[1] - hs_cyc[0], 3);
      check("const_gap_12", hs_cyc[2] - hs_cyc[1], 3);
      step();

      // Both requesters held valid: round-robin (or fixed priority)
      bus.req0_valid = 1'b1;
      bus.req0_sel   = 2'd0;
      bus.req0_data  = 8'h11;
      bus.req1_valid = 1'b1;
      bus.req1_sel   = 2'd0;
      bus.req1_data  = 8'h22;
      nhs  = 0;
      nrsp = 0;
      #1;
      for (int c = 0; c < 40 && nrsp < 4; c++) begin
         if (bus.rsp_valid) begin
            check("rr_rsp_id",   32'(bus.rsp_id),   gnt[nrsp]);
            check("rr_rsp_data", 32'(bus.rsp_data), (gnt[nrsp] != 0) ? 'h22 : 'h11);
            nrsp++;
         end
         check("rr_ready_excl", 32'(bus.req0_ready & bus.req1_ready), 0);
         if (bus.req0_ready || bus.req1_ready) begin
            if (nhs < 8) begin
               gnt[nhs] = int'(bus.req1_ready);
               check("rr_grant", gnt[nhs], FIXED ? 0 : (nhs & 1));
            end
            nhs++;
         end
         step();
      end
      check("rr_rsp_count", nrsp, 4);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      step();

      // Requester 0 alone so the pointer favours requester 1 before reset
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h33;
      #1;
      check("pre_req0_ready", 32'(bus.req0_ready), 1);
      step();
      bus.req0_valid = 1'b0;
      step();
      check("pre_rsp_data", 32'(bus.rsp_data), 'h33);
      step();

      // Reset pulsed during DRIVE
      bus.req1_valid = 1'b1;
      bus.req1_sel   = 2'd2;
      bus.req1_data  = 8'h77;
      #1;
      check("mid_req1_ready", 32'(bus.req1_ready), 1);
      step();
      bus.req1_valid = 1'b0;
      check("mid_mux_sel", 32'(bus.mux_sel), 2);
      check("mid_mux_in",  32'(bus.mux_in),  'h77);
      #2;
      rst = 1'b1;
      #1;
      check("arst_mux_sel",   32'(bus.mux_sel),   0);
      check("arst_mux_in",    32'(bus.mux_in),    0);
      check("arst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("arst_rsp_id",    32'(bus.rsp_id),    0);
      check("arst_rsp_data",  32'(bus.rsp_data),  0);
      #1;
      rst = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h11;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h22;
      bus.req1_sel   = 2'd0;
      #1;
      check("post_req0_ready", 32'(bus.req0_ready), 1);
      check("post_req1_ready", 32'(bus.req1_ready), 0);
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check("post_drive_rsp_valid", 32'(bus.rsp_valid), 0);
      step();
      check("post_rsp_valid", 32'(bus.rsp_valid), 1);
      check("post_rsp_id",    32'(bus.rsp_id),    0);
      check("post_rsp_data",  32'(bus.rsp_data),  'h11);
      step();
      check("post_done_rsp_valid", 32'(bus.rsp_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
